// File: rtl/aqp_ebus_pkg.sv
// Shared types and constants for the external Z80 bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aqp_ebus_pkg;

  localparam int MAX_MASTERS = 4;
  localparam int MASTER_SPI  = 0;
  localparam int MASTER_DMA  = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_ACK = 3'd2,
    GRANT    = 3'd3,
    TURN     = 3'd4,
    ACK_DROP = 3'd5
  } arb_state_t;

endpackage

// File: rtl/aqp_ebus_rr_pick.sv
// Round-robin picker: first requester strictly after last_i, wrapping to index 0.
// Latency: combinational.
// Backpressure: none; caller decides when to latch the result.
module aqp_ebus_rr_pick
  import aqp_ebus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   last_i,
  output logic [N-1:0] onehot_o,
  output logic [1:0]   index_o
);

  logic [N-1:0] upper;
  logic         found;

  // requesters ranked above the previous winner get first chance
  always_comb begin
    upper = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = req_i[i] && (i > int'(last_i));
    end
  end

  // lowest set bit of the upper group, else lowest set bit overall (wrap)
  always_comb begin
    onehot_o = '0;
    index_o  = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && upper[i]) begin
        found       = 1'b1;
        onehot_o[i] = 1'b1;
        index_o     = 2'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found       = 1'b1;
        onehot_o[i] = 1'b1;
        index_o     = 2'(i);
      end
    end
  end

endmodule

// File: rtl/aqp_ebus_arbiter.sv
// External Z80 bus handover: BUSREQ#/BUSACK# handshake, then round-robin grant to one master.
// Latency: grant registers SYNC_STAGES+1 clk after BUSACK# falls; decisions paced by ebus_phi_clken.
// Backpressure: masters hold req level; new requests wait for CPU time. EBUS_ARB_TIMEOUT_EN adds forced release.
module aqp_ebus_arbiter
  import aqp_ebus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TURNAROUND  = 2,
  parameter int MIN_CPU_PHI = 4,
  parameter int TIMEOUT_PHI = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ebus_phi_clken,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   bus_en,
  output logic [1:0]             owner,
  output logic                   ebus_busreq_n,
  input  logic                   ebus_busack_n,
  output logic                   timeout_err
);

  localparam int CPU_W  = $clog2(MIN_CPU_PHI + 1);
  localparam int TURN_W = $clog2(TURNAROUND + 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [1:0]             owner_q, owner_d;
  logic [1:0]             rr_q, rr_d;
  logic                   busreq_n_q, busreq_n_d;
  logic [CPU_W-1:0]       cpu_cnt_q, cpu_cnt_d;
  logic [TURN_W-1:0]      turn_cnt_q, turn_cnt_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [1:0]             pick_idx;

`ifdef EBUS_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_PHI + 1);
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic                   timeout_err_q, timeout_err_d;
  assign eligible    = req & ~mask_q;
  assign timeout_err = timeout_err_q;
`else
  assign eligible    = req;
  assign timeout_err = 1'b0;
`endif

  // BUSACK# is asynchronous to clk; reset value models "not acknowledged"
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_sync_q <= '1;
    else          ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ebus_busack_n};
  end
  assign ack = ~ack_sync_q[SYNC_STAGES-1];

  aqp_ebus_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i    (eligible),
    .last_i   (rr_q),
    .onehot_o (pick_onehot),
    .index_o  (pick_idx)
  );

  // state and registered outputs; CPU counter starts saturated so the first request is not delayed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_q       <= 2'(NUM_MASTERS - 1);
      busreq_n_q <= 1'b1;
      cpu_cnt_q  <= CPU_W'(MIN_CPU_PHI);
      turn_cnt_q <= '0;
`ifdef EBUS_ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      mask_q        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      busreq_n_q <= busreq_n_d;
      cpu_cnt_q  <= cpu_cnt_d;
      turn_cnt_q <= turn_cnt_d;
`ifdef EBUS_ARB_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      mask_q        <= mask_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // handover sequencing; every grant is bracketed by a trip through IDLE so the CPU gets its PHI cycles
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cpu_cnt_d  = cpu_cnt_q;
    turn_cnt_d = turn_cnt_q;
`ifdef EBUS_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    mask_d        = mask_q & req;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ebus_phi_clken) begin
          if (cpu_cnt_q == CPU_W'(MIN_CPU_PHI)) begin
            if (|eligible) state_d = REQ;
          end else begin
            cpu_cnt_d = cpu_cnt_q + 1'b1;
          end
        end
      end
      REQ: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (ack && |eligible) begin
          state_d = GRANT;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          rr_d    = pick_idx;
`ifdef EBUS_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else if (!(|eligible)) begin
          state_d = ACK_DROP;
        end
      end
      GRANT: begin
        if (!ack) begin
          // CPU took the bus back under us: release immediately, no turnaround
          grant_d = '0;
          state_d = ACK_DROP;
        end else if (!(|(req & grant_q))) begin
          grant_d    = '0;
          turn_cnt_d = '0;
          state_d    = TURN;
`ifdef EBUS_ARB_TIMEOUT_EN
        end else if (ebus_phi_clken && (to_cnt_q == TO_W'(TIMEOUT_PHI - 1))) begin
          grant_d       = '0;
          turn_cnt_d    = '0;
          state_d       = TURN;
          timeout_err_d = 1'b1;
          mask_d        = (mask_q & req) | grant_q;
        end else if (ebus_phi_clken) begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_W'(TURNAROUND - 1)) state_d = ACK_DROP;
        else                                       turn_cnt_d = turn_cnt_q + 1'b1;
      end
      ACK_DROP: begin
        if (!ack) begin
          state_d   = IDLE;
          cpu_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busreq_n_d = (state_d == IDLE) || (state_d == ACK_DROP);
  end

  assign grant         = grant_q;
  assign bus_en        = |grant_q;
  assign owner         = owner_q;
  assign ebus_busreq_n = busreq_n_q;

endmodule

// File: tb/tb_aqp_ebus_arbiter.sv
module tb_aqp_ebus_arbiter;

  localparam int N       = 2;
  localparam int SYNC    = 2;
  localparam int TURN    = 2;
  localparam int MINPHI  = 4;
  localparam int TOPHI   = 16;
  localparam int PHI_DIV = 4;
`ifdef EBUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         phi = 1'b0;
  logic [N-1:0] req = '0;
  logic         busack_n = 1'b1;
  logic [N-1:0] grant;
  logic         bus_en;
  logic [1:0]   owner;
  logic         busreq_n;
  logic         timeout_err;

  aqp_ebus_arbiter #(
    .NUM_MASTERS (N),
    .SYNC_STAGES (SYNC),
    .TURNAROUND  (TURN),
    .MIN_CPU_PHI (MINPHI),
    .TIMEOUT_PHI (TOPHI)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ebus_phi_clken (phi),
    .req            (req),
    .grant          (grant),
    .bus_en         (bus_en),
    .owner          (owner),
    .ebus_busreq_n  (busreq_n),
    .ebus_busack_n  (busack_n),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference-model state
  int           last_win = N - 1;
  bit           had_grant = 1'b0;
  bit           released = 1'b0;
  int           phi_since_drop = 0;
  int           phi_in_grant = 0;
  int           ack_low_ticks = 0;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] mask_model = '0;
  bit           rnd_chk = 1'b0;
  bit           auto_cpu = 1'b0;
  int           cpu_dly = 0;
  int           phi_div_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_expect(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    last_win = N - 1; had_grant = 1'b0; released = 1'b0;
    phi_since_drop = 0; phi_in_grant = 0; ack_low_ticks = 0;
    prev_grant = '0; mask_model = '0; cpu_dly = 0;
  endtask

  // observe one clock interval; req/phi/busack_n still hold the values the DUT just sampled
  task automatic monitor();
    bit           exp_to;
    logic [N-1:0] elig;
    int           e;
    if (busack_n == 1'b0) ack_low_ticks++; else ack_low_ticks = 0;
    if (prev_grant != 0 && phi) phi_in_grant++;
    if (prev_grant == 0 && phi) phi_since_drop++;
    exp_to = TO_EN && (prev_grant != 0) && phi && (phi_in_grant == TOPHI) && ((req & prev_grant) != 0);

    check("onehot0", $onehot0(grant), 1);
    check("bus_en", bus_en, |grant);
    check("timeout_err", timeout_err, exp_to);
    if (grant != 0) begin
      check("owner", owner, idx_of(grant));
      check("busreq_in_grant", busreq_n, 0);
    end

    if (prev_grant == 0 && grant != 0) begin
      elig = req & ~mask_model;
      e = rr_expect(elig, last_win);
      check("rr_winner", grant, (e < 0) ? 0 : (1 << e));
      check("ack_synced", ack_low_ticks >= SYNC + 1, 1);
      if (had_grant) begin
        check("cpu_min_phi", phi_since_drop >= MINPHI, 1);
        check("via_release", released, 1);
      end
      last_win = idx_of(grant);
      had_grant = 1'b1;
      phi_in_grant = 0;
    end

    if (rnd_chk && prev_grant != 0) begin
      if ((req & prev_grant) == 0 || exp_to) check("drop_or_hold", grant, 0);
      else                                   check("drop_or_hold", grant, prev_grant);
    end

    if (prev_grant != 0 && grant == 0) begin
      phi_since_drop = 0;
      released = 1'b0;
    end
    if (busreq_n) released = 1'b1;
    mask_model = mask_model & req;
    if (exp_to) mask_model[last_win] = 1'b1;
    prev_grant = grant;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
    phi_div_cnt = (phi_div_cnt + 1) % PHI_DIV;
    phi = (phi_div_cnt == 0);
    if (auto_cpu && busack_n != busreq_n) begin
      if (cpu_dly == 0) begin
        busack_n = busreq_n;
        cpu_dly = $urandom_range(0, 3);
      end else begin
        cpu_dly--;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; busack_n = 1'b1; req = '0; phi = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input int budget, input string tag);
    int t;
    t = 0;
    while (grant == 0 && t < budget) begin tick(); t++; end
    check(tag, grant, exp);
  endtask

  task automatic wait_busreq(input logic val, input int budget, input string tag);
    int t;
    t = 0;
    while (busreq_n !== val && t < budget) begin tick(); t++; end
    check(tag, busreq_n, val);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_bus_en", bus_en, 0);
    check("rst_owner", owner, 0);
    check("rst_busreq", busreq_n, 1);
    check("rst_timeout", timeout_err, 0);
    reset_n = 1'b1;

    // first grant latency, CPU answers 3 clk after BUSREQ#
    req = 2'b01;
    wait_busreq(1'b0, 40, "t1_busreq");
    repeat (3) tick();
    busack_n = 1'b0;
    for (int i = 1; i <= SYNC + 1; i++) begin
      tick();
      if (i <= SYNC) check("t1_grant_early", grant, 0);
    end
    check("t1_grant", grant, 2'b01);
    check("t1_owner", owner, 0);
    check("t1_bus_en", bus_en, 1);
    req = '0;
    auto_cpu = 1'b1;
    repeat (20) tick();

    // simultaneous requests, turnaround, second master after CPU time
    do_reset();
    req = 2'b11;
    wait_grant(2'b01, 100, "t2_first");
    req = 2'b10;
    tick();
    check("t2_drop", grant, 0);
    check("t2_turn0", busreq_n, 0);
    tick();
    check("t2_turn1", busreq_n, 0);
    tick();
    check("t2_release", busreq_n, 1);
    wait_grant(2'b10, 200, "t2_second");
    req = '0;
    repeat (30) tick();

    // request withdrawn before BUSACK#
    auto_cpu = 1'b0;
    req = 2'b10;
    wait_busreq(1'b0, 60, "t3_busreq");
    tick();
    req = '0;
    tick();
    check("t3_release", busreq_n, 1);
    repeat (10) tick();
    check("t3_idle_busreq", busreq_n, 1);
    check("t3_no_grant", grant, 0);

    // BUSACK# lost while granted
    req = 2'b01;
    wait_busreq(1'b0, 60, "t4_busreq");
    busack_n = 1'b0;
    wait_grant(2'b01, 20, "t4_grant");
    busack_n = 1'b1;
    tick();
    check("t4_hold1", grant, 2'b01);
    tick();
    check("t4_hold2", grant, 2'b01);
    tick();
    check("t4_drop", grant, 0);
    check("t4_busreq", busreq_n, 1);
    req = '0;
    repeat (10) tick();
    check("t4_idle_busreq", busreq_n, 1);

`ifdef EBUS_ARB_TIMEOUT_EN
    // forced release after TOPHI PHI pulses; master masked until req cycles low
    do_reset();
    auto_cpu = 1'b1;
    req = 2'b01;
    wait_grant(2'b01, 100, "t5_grant");
    begin
      int t;
      t = 0;
      while (grant != 0 && t < TOPHI * PHI_DIV + 20) begin tick(); t++; end
    end
    check("t5_dropped", grant, 0);
    check("t5_phi_count", phi_in_grant, TOPHI);
    check("t5_err_pulse", timeout_err, 1);
    tick();
    check("t5_err_once", timeout_err, 0);
    seen = 0;
    repeat (200) begin tick(); if (grant != 0) seen++; end
    check("t5_masked", seen, 0);
    req = '0;
    repeat (2) tick();
    req = 2'b01;
    wait_grant(2'b01, 200, "t5_regrant");
    req = '0;
    repeat (20) tick();
`endif

    // asynchronous reset during GRANT
    do_reset();
    auto_cpu = 1'b1;
    req = 2'b01;
    wait_grant(2'b01, 100, "t6_grant");
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_grant", grant, 0);
    check("t6_bus_en", bus_en, 0);
    check("t6_busreq", busreq_n, 1);
    check("t6_owner", owner, 0);
    do_reset();

    // randomized requests against the model
    rnd_chk = 1'b1;
    for (int it = 0; it < 150; it++) begin
      req = N'($urandom_range(0, 3));
      repeat ($urandom_range(1, 40)) tick();
    end
    req = '0;
    repeat (40) tick();
    rnd_chk = 1'b0;
    check("end_no_grant", grant, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
